// File: rtl/sram_io_bridge.sv
// Bridges the SLC-3 CPU memory port to an async 16-bit SRAM plus the MMIO word at 0xFFFF.
// CPU strobes are registered first; each request becomes one timed SRAM cycle acknowledged by Ready.
module sram_io_bridge #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_CE,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic        Mem_UB,
    input  logic        Mem_LB,
    input  logic [19:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    output logic [15:0] Data_to_CPU,
    output logic        Ready,
    output logic        Err,
    input  logic [15:0] Switches,
    output logic [15:0] Hex_out,
    output logic [19:0] sram_addr,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n,
    inout  wire  [15:0] sram_dq
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MMIO    = 3'd1;
    localparam logic [2:0] S_ACCESS  = 3'd2;
    localparam logic [2:0] S_RECOVER = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic        ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q;
    logic [19:0] addr_q;
    logic [15:0] wdat_q;
    logic [3:0]  cnt_q;
    logic [15:0] rdat_q;
    logic [15:0] hex_q;
    logic        err_q;

    logic        illegal_q, start, held, cap_en, is_wr, bus_act;

    function automatic logic [15:0] lane_mask(input logic [15:0] d, input logic ub_n, input logic lb_n);
        return {(ub_n ? 8'h00 : d[15:8]), (lb_n ? 8'h00 : d[7:0])};
    endfunction

    always_comb begin
        illegal_q = !ce_n_q && !oe_n_q && !we_n_q;
        start     = (state_q == S_IDLE) && !ce_n_q && (!oe_n_q || !we_n_q) && !illegal_q;
        held      = !Mem_CE && (!Mem_OE || !Mem_WE);
        // The request registers track the CPU port except while an access owns them.
        cap_en    = (state_q == S_DONE) || ((state_q == S_IDLE) && !start);
        is_wr     = !we_n_q;
        bus_act   = (state_q == S_ACCESS) || (state_q == S_RECOVER);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = (addr_q[15:0] == 16'hFFFF) ? S_MMIO : S_ACCESS;
            S_MMIO:    state_d = S_DONE;
            S_ACCESS:  if (cnt_q == 4'd0) state_d = S_RECOVER;
            S_RECOVER: state_d = S_DONE;
            S_DONE:    if (!held) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            addr_q  <= 20'h0;
            wdat_q  <= 16'h0;
            cnt_q   <= 4'h0;
            rdat_q  <= 16'h0;
            hex_q   <= 16'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cap_en) begin
                ce_n_q <= Mem_CE;
                oe_n_q <= Mem_OE;
                we_n_q <= Mem_WE;
                ub_n_q <= Mem_UB;
                lb_n_q <= Mem_LB;
                addr_q <= ADDR;
                wdat_q <= Data_from_CPU;
            end
            if ((state_q == S_IDLE) && illegal_q) err_q <= 1'b1;
            if (start) begin
                cnt_q <= CNT_INIT;
            end else if ((state_q == S_ACCESS) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (state_q == S_MMIO) begin
                if (is_wr) begin
                    if (!ub_n_q) hex_q[15:8] <= wdat_q[15:8];
                    if (!lb_n_q) hex_q[7:0]  <= wdat_q[7:0];
                end else begin
                    rdat_q <= lane_mask(Switches, ub_n_q, lb_n_q);
                end
            end
            // Read data is sampled at the end of the strobe window, while OE is still low.
            if ((state_q == S_ACCESS) && !is_wr && (cnt_q == 4'd0))
                rdat_q <= lane_mask(sram_dq, ub_n_q, lb_n_q);
        end
    end

    assign sram_addr   = addr_q;
    assign sram_ce_n   = !bus_act;
    assign sram_oe_n   = !((state_q == S_ACCESS) && !is_wr);
    assign sram_we_n   = !((state_q == S_ACCESS) && is_wr);
    assign sram_ub_n   = bus_act ? ub_n_q : 1'b1;
    assign sram_lb_n   = bus_act ? lb_n_q : 1'b1;
    assign sram_dq     = (bus_act && is_wr) ? wdat_q : 16'hzzzz;
    assign Ready       = (state_q == S_DONE);
    assign Err         = err_q;
    assign Hex_out     = hex_q;
    assign Data_to_CPU = rdat_q;

endmodule

// File: tb/tb_sram_io_bridge.sv
// Directed bench for sram_io_bridge with a behavioural async SRAM and a read-data scoreboard.
// A second instance with WAIT_CYCLES=5 is enabled only by its own chip enable.
module tb_sram_io_bridge;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Mem_CE = 1'b1, Mem_OE = 1'b1, Mem_WE = 1'b1, Mem_UB = 1'b0, Mem_LB = 1'b0;
    logic        ce5 = 1'b1;
    logic [19:0] ADDR = 20'h0;
    logic [15:0] Data_from_CPU = 16'h0;
    logic [15:0] Switches = 16'h0;

    logic [15:0] Data_to_CPU, Hex_out, d5, hex5;
    logic        Ready, Err, rdy5, err5;
    logic [19:0] sram_addr, addr5;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic        ce5_n, oe5_n, we5_n, ub5_n, lb5_n;
    wire  [15:0] sram_dq;
    wire  [15:0] dq5;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mem [0:65535];

    sram_io_bridge #(.WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
        .Data_to_CPU(Data_to_CPU), .Ready(Ready), .Err(Err), .Switches(Switches),
        .Hex_out(Hex_out), .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .sram_dq(sram_dq)
    );

    sram_io_bridge #(.WAIT_CYCLES(5)) dut5 (
        .Clk(Clk), .Reset(Reset), .Mem_CE(ce5), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
        .Data_to_CPU(d5), .Ready(rdy5), .Err(err5), .Switches(Switches),
        .Hex_out(hex5), .sram_addr(addr5), .sram_ce_n(ce5_n), .sram_oe_n(oe5_n),
        .sram_we_n(we5_n), .sram_ub_n(ub5_n), .sram_lb_n(lb5_n), .sram_dq(dq5)
    );

    always #5 Clk = ~Clk;

    // Async SRAM model: drives the bus during a read strobe, stores enabled lanes under WE.
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[15:0]] : 16'hzzzz;
    always @(posedge Clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) mem[sram_addr[15:0]][15:8] <= sram_dq[15:8];
            if (!sram_lb_n) mem[sram_addr[15:0]][7:0]  <= sram_dq[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, {16'h0, Data_to_CPU}, 32'h0);
        check({tag, "_hex"}, {16'h0, Hex_out}, 32'h0);
        check({tag, "_addr"}, {12'h0, sram_addr}, 32'h0);
        check({tag, "_rdy_err"}, {30'h0, Ready, Err}, 32'h0);
        check({tag, "_strobes"}, {27'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
    endtask

    task automatic do_access(input string tag, input logic wr, input logic [19:0] a, input logic [15:0] d,
                             input logic ub_n, input logic lb_n, input int exp_lat, input int exp_ce,
                             input int exp_we, input logic [15:0] exp_rd);
        int n, ce_cnt, we_cnt;
        logic [15:0] exp_val;
        if (!wr) exp_q.push_back(exp_rd);
        ADDR = a; Data_from_CPU = d; Mem_UB = ub_n; Mem_LB = lb_n;
        Mem_OE = wr; Mem_WE = !wr; Mem_CE = 1'b0;
        n = 0; ce_cnt = 0; we_cnt = 0;
        tick();
        do begin
            tick();
            n++;
            if (!sram_ce_n) ce_cnt++;
            if (!sram_we_n) we_cnt++;
        end while (!Ready && n < 40);
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_ce_cycles"}, ce_cnt, exp_ce);
        check({tag, "_we_cycles"}, we_cnt, exp_we);
        if (!wr && exp_q.size() > 0) begin
            exp_val = exp_q.pop_front();
            check({tag, "_rdata"}, {16'h0, Data_to_CPU}, {16'h0, exp_val});
        end
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
        tick();
        check({tag, "_ready_fall"}, {31'h0, Ready}, 32'h0);
    endtask

    initial begin
        int n, pulses;
        logic prev_oe, bad_strobe, bad_ready, got, saw_dq;
        logic [15:0] exp_val;

        tick();
        tick();
        check_reset_outputs("reset");
        check("reset_dut5", {rdy5, err5, ce5_n, oe5_n, we5_n, ub5_n, lb5_n, 25'h0} | {16'h0, d5 | hex5},
              {2'b00, 5'b11111, 25'h0});
        check("reset_addr5", {12'h0, addr5}, 32'h0);
        Reset = 1'b0;
        tick();

        do_access("wr_0010", 1'b1, 20'h00010, 16'h1234, 1'b0, 1'b0, 4, 3, 2, 16'h0);
        do_access("wr_0042", 1'b1, 20'h00042, 16'hBEEF, 1'b0, 1'b0, 4, 3, 2, 16'h0);
        do_access("rd_0042", 1'b0, 20'h00042, 16'h0000, 1'b0, 1'b0, 4, 3, 0, 16'hBEEF);
        do_access("wr_lb",   1'b1, 20'h00042, 16'h12AA, 1'b1, 1'b0, 4, 3, 2, 16'h0);
        do_access("rd_after_lb", 1'b0, 20'h00042, 16'h0000, 1'b0, 1'b0, 4, 3, 0, 16'hBEAA);
        do_access("rd_ub",   1'b0, 20'h00042, 16'h0000, 1'b0, 1'b1, 4, 3, 0, 16'hBE00);

        Switches = 16'h3C5A;
        do_access("mmio_rd", 1'b0, 20'h0FFFF, 16'h0000, 1'b0, 1'b0, 2, 0, 0, 16'h3C5A);
        do_access("mmio_rd_lb", 1'b0, 20'h0FFFF, 16'h0000, 1'b1, 1'b0, 2, 0, 0, 16'h005A);
        do_access("mmio_wr", 1'b1, 20'h0FFFF, 16'h0123, 1'b0, 1'b0, 2, 0, 0, 16'h0);
        check("mmio_hex", {16'h0, Hex_out}, 32'h0123);
        do_access("mmio_wr_lb", 1'b1, 20'h0FFFF, 16'hAB67, 1'b1, 1'b0, 2, 0, 0, 16'h0);
        check("mmio_hex_lb", {16'h0, Hex_out}, 32'h0167);

        // Held read: one strobe pulse, Ready sticks until the CPU lets go.
        exp_q.push_back(16'h1234);
        ADDR = 20'h00010; Mem_UB = 1'b0; Mem_LB = 1'b0; Mem_WE = 1'b1; Mem_OE = 1'b0; Mem_CE = 1'b0;
        pulses = 0; prev_oe = 1'b1; got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (prev_oe && !sram_oe_n) pulses++;
            prev_oe = sram_oe_n;
            if (Ready && !got) begin
                got = 1'b1;
                exp_val = exp_q.pop_front();
                check("held_rdata", {16'h0, Data_to_CPU}, {16'h0, exp_val});
            end
        end
        check("held_pulses", pulses, 1);
        check("held_ready", {31'h0, Ready}, 32'h1);
        Mem_CE = 1'b1;
        tick();
        check("held_ready_fall", {31'h0, Ready}, 32'h0);

        Mem_OE = 1'b0; Mem_WE = 1'b0; Mem_CE = 1'b0;
        bad_strobe = 1'b0; bad_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!sram_ce_n || !sram_oe_n || !sram_we_n) bad_strobe = 1'b1;
            if (Ready) bad_ready = 1'b1;
        end
        check("illegal_no_strobe", {31'h0, bad_strobe}, 32'h0);
        check("illegal_no_ready", {31'h0, bad_ready}, 32'h0);
        check("illegal_err", {31'h0, Err}, 32'h1);
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
        tick(); tick(); tick();
        check("illegal_err_sticky", {31'h0, Err}, 32'h1);

        ADDR = 20'h00050; Data_from_CPU = 16'hA5C3; Mem_OE = 1'b1; Mem_WE = 1'b0; Mem_CE = 1'b0;
        n = 0;
        tick();
        while (sram_we_n && n < 20) begin
            tick();
            n++;
        end
        check("rstmid_reached_access", {31'h0, sram_we_n}, 32'h0);
        #2 Reset = 1'b1;
        #1;
        check("rstmid_we_n", {30'h0, sram_we_n, sram_ce_n}, 32'h3);
        check("rstmid_dq_released", {31'h0, sram_dq === 16'hA5C3}, 32'h0);
        Mem_CE = 1'b1; Mem_WE = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        #1;
        check_reset_outputs("post_reset");
        tick();
        do_access("fresh_wr", 1'b1, 20'h00050, 16'hA5C3, 1'b0, 1'b0, 4, 3, 2, 16'h0);
        do_access("fresh_rd", 1'b0, 20'h00050, 16'h0000, 1'b0, 1'b0, 4, 3, 0, 16'hA5C3);

        ADDR = 20'h00060; Data_from_CPU = 16'h5AA5; Mem_OE = 1'b1; Mem_WE = 1'b0; ce5 = 1'b0;
        n = 0; saw_dq = 1'b0;
        tick();
        do begin
            tick();
            n++;
            if (!we5_n && dq5 === 16'h5AA5) saw_dq = 1'b1;
        end while (!rdy5 && n < 40);
        check("w5_latency", n, 7);
        check("w5_dq_driven", {31'h0, saw_dq}, 32'h1);
        check("w5_dut2_idle", {31'h0, sram_ce_n}, 32'h1);
        ce5 = 1'b1; Mem_WE = 1'b1;
        tick();
        check("w5_ready_fall", {31'h0, rdy5}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
